hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline hazard detector. It tracks in-flight register writes in a shadow shift register of issued destinations instead of comparing raw pipeline-register fields. From that state it stalls decode on RAW hazards and generates multi-cycle fetch/decode flushes on taken control transfers.
It resolves STU (writes Rs) and JAL/JALR (write R7) destinations internally, supports an external pipeline hold, and keeps a saturating stall-cycle counter. It sits beside the decode stage and drives the IF/ID and ID/EX pipeline-register controls.

Parameters:
REG_W, 3, register-specifier width (2**REG_W architectural registers)
OP_W, 5, opcode width
PIPE_DEPTH, 3, stages between ID issue and register-file write (ID/EX, EX/MEM, MEM/WB); ≥1
FLUSH_CYCLES, 1, cycles flush_fetch stays high per taken branch; ≥1
LINK_REG, 7, register written by JAL/JALR
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_op  in  OP_W  ID opcode
id_rs  in  REG_W  ID Rs field
id_rt  in  REG_W  ID Rt field
id_rd  in  REG_W  ID Rd (already selected by decoder for normal ALU/load ops)
id_rs_used  in  1  instruction reads Rs
id_rt_used  in  1  instruction reads Rt
id_reg_write  in  1  instruction writes a register
br_taken  in  1  EX resolved a taken branch/jump (PC_source==2'b10)
hold_pipe  in  1  downstream (memory) stall; freezes whole pipe
stall_decode  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush_fetch  out  1  squash IF/ID and ID contents
stall_cycles  out  CNT_W  saturating count of RAW stall cycles

Behaviour:
- Destination resolve: STU (5'b10011) → id_rs; JAL (5'b00110) or JALR (5'b00111) → LINK_REG; else id_rd. wr_en = id_reg_write | STU | JAL | JALR.
- Shadow: PIPE_DEPTH entries {valid, dst, is_load}. Entry 0 is ID/EX, entry PIPE_DEPTH-1 is MEM/WB. is_load = (id_op==5'b10001).
- Shift rule: each clock with hold_pipe=0, entries shift toward the last one. The oldest entry retires.
- Entry 0 loads {1, dst, is_load} only when issue = id_valid & wr_en & ~stall_decode & ~flush_fetch. Otherwise entry 0 loads a bubble (valid=0).
- With hold_pipe=1: shadow, flush counter and stall_cycles are frozen; stall_decode=1; br_taken is ignored.
- RAW (combinational): any valid entry k with dst==id_rs & id_rs_used, or dst==id_rt & id_rt_used. RAW is qualified by id_valid.
- stall_decode = hold_pipe | (RAW & ~flush_fetch). Flush wins over RAW on simultaneous events.
- Flush: flush_fetch = br_taken | (fcnt≠0). On br_taken with hold_pipe=0, fcnt loads FLUSH_CYCLES-1; otherwise fcnt decrements to 0. A new br_taken during a flush reloads fcnt.
- stall_cycles increments each cycle RAW stall (not hold) is asserted and saturates at all-ones.
- Latency: a dependent instruction directly behind a producer stalls PIPE_DEPTH cycles (default 3) and issues in the cycle after the producer leaves MEM/WB.
- Reset: all shadow entries invalid, fcnt=0, stall_cycles=0. In the reset cycle stall_decode=0 and flush_fetch=0, regardless of inputs. Reset mid-flush or mid-stall clears immediately.

Optional Feature:
FWD_STALL_EN. When defined, a full EX/MEM/WB forwarding network is assumed. RAW then only considers entry 0 when its is_load=1 (load-use), so there is one stall cycle for load-use and none otherwise. Without it, all PIPE_DEPTH entries are checked as above.

Test Plan:
- ADD r1 issued then ADD r2,r1,r3 (no FWD_STALL_EN) → stall_decode high exactly 3 cycles; consumer issues on 4th; stall_cycles=3.
- STU r4 then reader of r4 as Rt; JAL then reader of r7 → each stalls 3 cycles; reader of r5 after STU r4 → no stall.
- br_taken pulse with FLUSH_CYCLES=3 while ID has a RAW hazard → flush_fetch high 3 cycles, stall_decode 0 in those cycles, squashed instruction never enters shadow.
- hold_pipe high 4 cycles mid-stall → shadow frozen, stall_decode 1 throughout; on release, the remaining RAW stall count is unchanged from before the hold.
- FWD_STALL_EN: LD r2 then ADD using r2 → 1 stall cycle; ADD r2 then ADD using r2 → 0 stalls.
- Assert rst during an active flush with a full shadow → next cycle all outputs 0 and the prior hazard register is no longer flagged; CNT_W=2 with 5 stalls → stall_cycles stays at 3.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bus of the hazard scoreboard.
// Handshake: the ID stage presents one instruction per cycle, qualified by
// id_valid. That instruction is accepted (issued) on the rising edge at which
// id_valid=1 and both stall_decode and flush_fetch are 0. While stall_decode=1
// the ID stage must hold its instruction unchanged.
interface hazard_scoreboard_if #(
  parameter int REG_W = 3,
  parameter int OP_W  = 5,
  parameter int CNT_W = 16
) ();
  logic             id_valid;
  logic [OP_W-1:0]  id_op;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_reg_write;
  logic             br_taken;
  logic             hold_pipe;
  logic             stall_decode;
  logic             flush_fetch;
  logic [CNT_W-1:0] stall_cycles;

  // Decoder / pipeline side drives the instruction, receives the controls.
  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_reg_write, br_taken, hold_pipe,
    input  stall_decode, flush_fetch, stall_cycles
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_reg_write, br_taken, hold_pipe,
    output stall_decode, flush_fetch, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow shift register of issued destinations, RAW
// decode stall, multi-cycle fetch flush on taken branches, and a saturating
// RAW stall-cycle counter.
// Optional build macro FWD_STALL_EN: assume full forwarding, so only a
// load in ID/EX (load-use) causes a stall.
module hazard_scoreboard #(
  parameter int REG_W        = 3,
  parameter int OP_W         = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int LINK_REG     = 7,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  localparam logic [OP_W-1:0] OP_STU  = OP_W'(5'b10011);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b10001);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Shadow entry 0 mirrors ID/EX, entry PIPE_DEPTH-1 mirrors MEM/WB.
  logic [PIPE_DEPTH-1:0]            sh_valid_q, sh_valid_d;
  logic [PIPE_DEPTH-1:0]            sh_load_q, sh_load_d;
  logic [PIPE_DEPTH-1:0][REG_W-1:0] sh_dst_q, sh_dst_d;
  logic [FC_W-1:0]                  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic             is_stu, is_jal, is_ld, wr_en;
  logic [REG_W-1:0] dst;
  logic             raw, br_eff, flush, stall, raw_stall, issue;

  // Resolve the destination the ID instruction will write, if any.
  always_comb begin
    is_stu = (bus.id_op == OP_STU);
    is_jal = (bus.id_op == OP_JAL) || (bus.id_op == OP_JALR);
    is_ld  = (bus.id_op == OP_LD);
    wr_en  = bus.id_reg_write | is_stu | is_jal;
    if (is_stu)      dst = bus.id_rs;
    else if (is_jal) dst = REG_W'(LINK_REG);
    else             dst = bus.id_rd;
  end

  // RAW detection of the ID operands against the in-flight destinations.
  always_comb begin
    raw = 1'b0;
`ifdef FWD_STALL_EN
    // Forwarding covers everything except a load still in ID/EX.
    if (sh_valid_q[0] && sh_load_q[0] &&
        ((bus.id_rs_used && sh_dst_q[0] == bus.id_rs) ||
         (bus.id_rt_used && sh_dst_q[0] == bus.id_rt)))
      raw = 1'b1;
`else
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (sh_valid_q[k] &&
          ((bus.id_rs_used && sh_dst_q[k] == bus.id_rs) ||
           (bus.id_rt_used && sh_dst_q[k] == bus.id_rt)))
        raw = 1'b1;
    end
`endif
    raw = raw & bus.id_valid;
  end

  // Pipeline controls; reset forces them low. A held pipe ignores branches.
  always_comb begin
    br_eff    = bus.br_taken & ~bus.hold_pipe;
    flush     = ~rst & (br_eff | (fcnt_q != '0));
    stall     = ~rst & (bus.hold_pipe | (raw & ~flush));
    raw_stall = ~rst & ~bus.hold_pipe & raw & ~flush;
    issue     = bus.id_valid & wr_en & ~stall & ~flush;
  end

  assign bus.stall_decode = stall;
  assign bus.flush_fetch  = flush;
  assign bus.stall_cycles = cnt_q;

  // Next state: shadow shift, flush countdown, saturating stall counter.
  always_comb begin
    sh_valid_d = sh_valid_q;
    sh_load_d  = sh_load_q;
    sh_dst_d   = sh_dst_q;
    fcnt_d     = fcnt_q;
    cnt_d      = cnt_q;
    if (!bus.hold_pipe) begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        sh_valid_d[k] = sh_valid_q[k-1];
        sh_load_d[k]  = sh_load_q[k-1];
        sh_dst_d[k]   = sh_dst_q[k-1];
      end
      sh_valid_d[0] = issue;
      sh_load_d[0]  = issue & is_ld;
      sh_dst_d[0]   = issue ? dst : '0;
      if (br_eff)              fcnt_d = FC_W'(FLUSH_CYCLES - 1);
      else if (fcnt_q != '0)   fcnt_d = fcnt_q - 1'b1;
    end
    if (raw_stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid_q <= '0;
      sh_load_q  <= '0;
      sh_dst_q   <= '0;
      fcnt_q     <= '0;
      cnt_q      <= '0;
    end else begin
      sh_valid_q <= sh_valid_d;
      sh_load_q  <= sh_load_d;
      sh_dst_q   <= sh_dst_d;
      fcnt_q     <= fcnt_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: main instance (FLUSH_CYCLES=3,
// CNT_W=16) plus a mirror instance with CNT_W=2 for counter saturation.
module tb_hazard_scoreboard;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b00110;
`ifdef FWD_STALL_EN
  localparam int EXP_LU  = 1;
  localparam int EXP_ALU = 0;
`else
  localparam int EXP_LU  = 3;
  localparam int EXP_ALU = 3;
`endif

  logic clk, rst;
  int   checks, errors;

  hazard_scoreboard_if #(.REG_W(3), .OP_W(5), .CNT_W(16)) bus ();
  hazard_scoreboard_if #(.REG_W(3), .OP_W(5), .CNT_W(2))  sat ();

  hazard_scoreboard #(.FLUSH_CYCLES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  hazard_scoreboard #(.FLUSH_CYCLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(sat));

  assign sat.id_valid     = bus.id_valid;
  assign sat.id_op        = bus.id_op;
  assign sat.id_rs        = bus.id_rs;
  assign sat.id_rt        = bus.id_rt;
  assign sat.id_rd        = bus.id_rd;
  assign sat.id_rs_used   = bus.id_rs_used;
  assign sat.id_rt_used   = bus.id_rt_used;
  assign sat.id_reg_write = bus.id_reg_write;
  assign sat.br_taken     = bus.br_taken;
  assign sat.hold_pipe    = bus.hold_pipe;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_idle();
    bus.id_valid = 0; bus.id_op = OP_ADD; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rd = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_reg_write = 0; bus.br_taken = 0; bus.hold_pipe = 0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic ru, input logic tu, input logic wr);
    bus.id_valid = 1; bus.id_op = op; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_rd = rd; bus.id_rs_used = ru; bus.id_rt_used = tu;
    bus.id_reg_write = wr;
  endtask

  task automatic do_reset();
    rst = 1; set_idle();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Holds the current ID instruction until it issues; returns stall cycles.
  task automatic run_until_issue(output int n);
    n = 0;
    @(negedge clk);
    while (bus.stall_decode && n < 10) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(OP_ADD, 3'd1, 3'd1, 3'd1, 1, 1, 1);
    bus.br_taken = 1; bus.hold_pipe = 1;
    @(negedge clk);
    checks++;
    if (bus.flush_fetch !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got %b want 0", bus.flush_fetch);
    end
    checks++;
    if (bus.stall_decode !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_decode);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cycles);
    end
    @(posedge clk); #1;
    rst = 0; set_idle();
  endtask

  task automatic test_raw_add();
    int n;
    do_reset();
    drive(OP_ADD, 3'd0, 3'd0, 3'd1, 0, 0, 1);
    run_until_issue(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL raw_producer: got %0d want 0", n); end
    drive(OP_ADD, 3'd1, 3'd3, 3'd2, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.stall_decode !== (i < 3)) begin
        errors++;
        $display("FAIL raw_stall_c%0d: got %b want %b", i, bus.stall_decode, (i < 3));
      end
      @(posedge clk); #1;
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.stall_cycles !== 16'd3) begin
      errors++; $display("FAIL raw_cnt: got %0d want 3", bus.stall_cycles);
    end
    @(posedge clk); #1;
    // Consumer wrote r2 and must itself be tracked now.
    do_reset();
    drive(OP_ADD, 3'd1, 3'd3, 3'd2, 0, 0, 1);
    run_until_issue(n);
    drive(OP_ADD, 3'd2, 3'd0, 3'd0, 1, 0, 0);
    run_until_issue(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL raw_r2_tracked: got %0d want 3", n); end
    set_idle();
  endtask

  task automatic test_stu_jal();
    int n;
    do_reset();
    drive(OP_STU, 3'd4, 3'd0, 3'd6, 0, 0, 0);
    run_until_issue(n);
    drive(OP_ADD, 3'd0, 3'd4, 3'd0, 0, 1, 0);
    run_until_issue(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL stu_rt: got %0d want 3", n); end
    drive(OP_JAL, 3'd0, 3'd0, 3'd2, 0, 0, 0);
    run_until_issue(n);
    drive(OP_ADD, 3'd7, 3'd0, 3'd0, 1, 0, 0);
    run_until_issue(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL jal_r7: got %0d want 3", n); end
    drive(OP_STU, 3'd4, 3'd0, 3'd6, 0, 0, 0);
    run_until_issue(n);
    drive(OP_ADD, 3'd5, 3'd6, 3'd0, 1, 1, 0);
    run_until_issue(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL stu_other: got %0d want 0", n); end
    set_idle();
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    drive(OP_ADD, 3'd0, 3'd0, 3'd1, 0, 0, 1);
    run_until_issue(n);
    drive(OP_ADD, 3'd1, 3'd0, 3'd2, 1, 0, 1);
    bus.br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.flush_fetch !== 1'b1) begin
        errors++; $display("FAIL flush_c%0d: got %b want 1", i, bus.flush_fetch);
      end
      checks++;
      if (bus.stall_decode !== 1'b0) begin
        errors++; $display("FAIL flush_stall_c%0d: got %b want 0", i, bus.stall_decode);
      end
      @(posedge clk); #1;
      bus.br_taken = 0;
    end
    // Reader of r2: only the squashed instruction could have written it.
    drive(OP_ADD, 3'd2, 3'd0, 3'd0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.flush_fetch !== 1'b0) begin
      errors++; $display("FAIL flush_end: got %b want 0", bus.flush_fetch);
    end
    checks++;
    if (bus.stall_decode !== 1'b0) begin
      errors++; $display("FAIL squash_entered: got %b want 0", bus.stall_decode);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL flush_cnt: got %0d want 0", bus.stall_cycles);
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_hold();
    int n;
    do_reset();
    drive(OP_ADD, 3'd0, 3'd0, 3'd1, 0, 0, 1);
    run_until_issue(n);
    drive(OP_ADD, 3'd1, 3'd0, 3'd3, 1, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.stall_decode !== 1'b1) begin
      errors++; $display("FAIL hold_pre: got %b want 1", bus.stall_decode);
    end
    @(posedge clk); #1;
    bus.hold_pipe = 1;
    bus.br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.stall_decode !== 1'b1 || bus.flush_fetch !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: stall %b flush %b want 1 0", i,
                 bus.stall_decode, bus.flush_fetch);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL hold_cnt_frozen: got %0d want 1", bus.stall_cycles);
    end
    bus.hold_pipe = 0;
    bus.br_taken = 0;
    run_until_issue(n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL hold_remaining: got %0d want 2", n); end
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.stall_cycles !== 16'd3) begin
      errors++; $display("FAIL hold_cnt: got %0d want 3", bus.stall_cycles);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd();
    int n;
    do_reset();
    drive(OP_LD, 3'd0, 3'd0, 3'd2, 0, 0, 1);
    run_until_issue(n);
    drive(OP_ADD, 3'd2, 3'd4, 3'd3, 1, 1, 1);
    run_until_issue(n);
    checks++;
    if (n !== EXP_LU) begin errors++; $display("FAIL load_use: got %0d want %0d", n, EXP_LU); end
    do_reset();
    drive(OP_ADD, 3'd0, 3'd0, 3'd2, 0, 0, 1);
    run_until_issue(n);
    drive(OP_ADD, 3'd4, 3'd2, 3'd3, 1, 1, 1);
    run_until_issue(n);
    checks++;
    if (n !== EXP_ALU) begin errors++; $display("FAIL alu_use: got %0d want %0d", n, EXP_ALU); end
    set_idle();
  endtask

  task automatic test_rst_flush();
    int n;
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      drive(OP_ADD, 3'd0, 3'd0, 3'(r), 0, 0, 1);
      run_until_issue(n);
    end
    drive(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 0, 0);
    bus.br_taken = 1;
    @(negedge clk);
    checks++;
    if (bus.flush_fetch !== 1'b1 || bus.stall_decode !== 1'b0) begin
      errors++;
      $display("FAIL rstf_pre: flush %b stall %b want 1 0", bus.flush_fetch, bus.stall_decode);
    end
    @(posedge clk); #1;
    bus.br_taken = 0;
    rst = 1;
    drive(OP_ADD, 3'd3, 3'd0, 3'd0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.flush_fetch !== 1'b0 || bus.stall_decode !== 1'b0) begin
      errors++;
      $display("FAIL rstf_in_reset: flush %b stall %b want 0 0", bus.flush_fetch, bus.stall_decode);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.flush_fetch !== 1'b0 || bus.stall_decode !== 1'b0 ||
        bus.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL rstf_after: flush %b stall %b cnt %0d want 0 0 0",
               bus.flush_fetch, bus.stall_decode, bus.stall_cycles);
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      drive(OP_ADD, 3'd0, 3'd0, 3'd1, 0, 0, 1);
      run_until_issue(n);
      drive(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 0, 0);
      run_until_issue(n);
      set_idle();
      checks++;
      if (sat.stall_cycles !== 2'd3) begin
        errors++; $display("FAIL sat_cnt_p%0d: got %0d want 3", p, sat.stall_cycles);
      end
      checks++;
      if (bus.stall_cycles !== 16'(3 * (p + 1))) begin
        errors++;
        $display("FAIL sat_main_p%0d: got %0d want %0d", p, bus.stall_cycles, 3 * (p + 1));
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; set_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw_add();
    test_stu_jal();
    test_flush();
    test_hold();
    test_fwd();
    test_rst_flush();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
